// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall sequencer for the 5-stage pipeline: operand forwarding, load-use stall,
// req/ack memory wait FSM with timeout, and multi-slot branch flush. Optional DEBUG_STEP_EN adds single-step gating.
module pipe_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int MEM_TMO   = 15,
  parameter int BR_FLUSH  = 1,
  localparam int SW       = $clog2(FWD_DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rs_used,
  input  logic                        rt_used,
  input  logic                        is_store,
  input  logic [REG_AW-1:0]           addr_rs,
  input  logic [REG_AW-1:0]           addr_rt,
  input  logic [FWD_DEPTH*REG_AW-1:0] prod_addr,
  input  logic [FWD_DEPTH-1:0]        prod_wen,
  input  logic [FWD_DEPTH-1:0]        prod_load,
  input  logic                        jump_en,
  input  logic                        imem_req,
  input  logic                        imem_ack,
  input  logic                        dmem_req,
  input  logic                        dmem_ack,
`ifdef DEBUG_STEP_EN
  input  logic                        debug_en,
  input  logic                        debug_step,
`endif
  output logic [SW-1:0]               fwd_a_sel,
  output logic [SW-1:0]               fwd_b_sel,
  output logic                        mem_fwd_m,
  output logic                        load_stall,
  output logic [4:0]                  stage_en,
  output logic [4:0]                  stage_rst,
  output logic                        mem_timeout
);

  typedef enum logic [1:0] {IDLE, IWAIT, DWAIT, TMO} state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO-1);
  localparam logic [2:0] FL_RUN   = 3'(BR_FLUSH-1);
  localparam logic [2:0] FL_HOLD  = 3'(BR_FLUSH);

  state_t     state, nxt;
  logic [7:0] wait_cnt;
  logic [2:0] flush_cnt;
  logic       rs_ld, rt_ld, d_wait, i_wait, flush, hold, dbg_gate;

  // Scan from the far stage down so the nearest producer overrides.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (rs_used && prod_wen[k] && prod_addr[k*REG_AW +: REG_AW] != '0 &&
          prod_addr[k*REG_AW +: REG_AW] == addr_rs)
        fwd_a_sel = SW'(k+1);
      if (rt_used && prod_wen[k] && prod_addr[k*REG_AW +: REG_AW] != '0 &&
          prod_addr[k*REG_AW +: REG_AW] == addr_rt)
        fwd_b_sel = SW'(k+1);
    end
  end

  assign rs_ld      = (fwd_a_sel == SW'(1)) && prod_load[0];
  assign rt_ld      = (fwd_b_sel == SW'(1)) && prod_load[0];
  // A store only needs rt in MEM, so the loaded value can be forwarded there instead of stalling.
  assign mem_fwd_m  = rt_ld && is_store && !rs_ld;
  assign load_stall = rs_ld || (rt_ld && !is_store);

`ifdef DEBUG_STEP_EN
  logic debug_step_prev;
  always_ff @(posedge clk)
    if (rst) debug_step_prev <= 1'b0;
    else     debug_step_prev <= debug_step;
  assign dbg_gate = debug_en && !(debug_step && !debug_step_prev);
`else
  assign dbg_gate = 1'b0;
`endif

  assign d_wait      = (state == DWAIT) || (state == IDLE && dmem_req && !dmem_ack);
  assign i_wait      = (state == IWAIT) || (state == IDLE && imem_req && !imem_ack);
  assign flush       = jump_en || (flush_cnt != '0);
  assign hold        = d_wait || i_wait || (state == TMO) || dbg_gate;
  assign mem_timeout = (state == TMO) && !rst;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (dmem_req && !dmem_ack)      nxt = DWAIT;
               else if (imem_req && !imem_ack) nxt = IWAIT;
      IWAIT:   if (imem_ack)                   nxt = IDLE;
               else if (wait_cnt == TMO_LAST)  nxt = TMO;
      DWAIT:   if (dmem_ack)                   nxt = IDLE;
               else if (wait_cnt == TMO_LAST)  nxt = TMO;
      default:                                 nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= nxt;
      if ((state == IWAIT || state == DWAIT) && nxt == state) wait_cnt <= wait_cnt + 8'd1;
      else                                                    wait_cnt <= '0;
      // A jump masked by a wait has not consumed its first slot yet.
      if (jump_en)                      flush_cnt <= hold ? FL_HOLD : FL_RUN;
      else if (!hold && flush_cnt != 0) flush_cnt <= flush_cnt - 3'd1;
    end
  end

  always_comb begin
    stage_en  = 5'h1F;
    stage_rst = 5'h00;
    if (rst) begin
      stage_rst = 5'h1F;
    end else if (state == TMO) begin
      stage_rst = 5'b00111;
    end else if (dbg_gate) begin
      stage_en  = 5'h00;
    end else if (d_wait) begin
      stage_en  = 5'b10000;
      stage_rst = 5'b10000;
    end else if (i_wait || load_stall) begin
      stage_en  = 5'b11100;
      stage_rst = 5'b00100;
    end else if (flush) begin
      stage_rst = 5'b00010;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: forwarding, load-use, memory timeout, flush and reset.
module tb_pipe_hazard_unit;
  logic        clk, rst, rs_used, rt_used, is_store, jump_en;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic [4:0]  addr_rs, addr_rt;
  logic [14:0] prod_addr;
  logic [2:0]  prod_wen, prod_load;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        mem_fwd_m, load_stall, mem_timeout;
  logic [4:0]  stage_en, stage_rst;
  int          errors = 0, checks = 0, got;

  pipe_hazard_unit #(.REG_AW(5), .FWD_DEPTH(3), .MEM_TMO(15), .BR_FLUSH(3)) dut (
    .clk(clk), .rst(rst), .rs_used(rs_used), .rt_used(rt_used), .is_store(is_store),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .prod_addr(prod_addr), .prod_wen(prod_wen),
    .prod_load(prod_load), .jump_en(jump_en), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_fwd_m(mem_fwd_m), .load_stall(load_stall), .stage_en(stage_en),
    .stage_rst(stage_rst), .mem_timeout(mem_timeout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs_used = 0; rt_used = 0; is_store = 0; jump_en = 0;
    imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
    addr_rs = 0; addr_rt = 0; prod_addr = 0; prod_wen = 0; prod_load = 0;
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk); #1;
    chk("rst_en", stage_en, 5'h1F);
    chk("rst_rst", stage_rst, 5'h1F);
    chk("rst_tmo", mem_timeout, 0);
    @(negedge clk); rst = 0; #1;
    chk("idle_en", stage_en, 5'h1F);
    chk("idle_rst", stage_rst, 5'h00);
    chk("idle_fwd_a", fwd_a_sel, 0);

    // T1: nearest producer wins
    @(negedge clk); prod_addr = {5'd0, 5'd5, 5'd5}; prod_wen = 3'b011; addr_rs = 5; rs_used = 1; #1;
    chk("t1_nearest", fwd_a_sel, 1);
    prod_wen = 3'b010; #1;
    chk("t1_stage1", fwd_a_sel, 2);
    prod_addr = {5'd9, 5'd0, 5'd0}; prod_wen = 3'b111; addr_rs = 9; addr_rt = 9; rt_used = 1; #1;
    chk("t1_wb_a", fwd_a_sel, 3);
    chk("t1_wb_b", fwd_b_sel, 3);
    addr_rs = 0; rs_used = 1; #1;
    chk("t1_zero_addr", fwd_a_sel, 0);
    rt_used = 0; #1;
    chk("t1_rt_unused", fwd_b_sel, 0);

    // T2: load-use on rs
    @(negedge clk); idle(); prod_addr = {5'd0, 5'd0, 5'd8}; prod_wen = 3'b001; prod_load = 3'b001;
    addr_rs = 8; rs_used = 1; #1;
    chk("t2_stall", load_stall, 1);
    chk("t2_en", stage_en, 5'b11100);
    chk("t2_rst", stage_rst, 5'b00100);

    // T3: store data from load forwards in MEM
    addr_rs = 3; addr_rt = 8; rt_used = 1; is_store = 1; #1;
    chk("t3_memfwd", mem_fwd_m, 1);
    chk("t3_nostall", load_stall, 0);
    chk("t3_en", stage_en, 5'h1F);
    is_store = 0; #1;
    chk("t3_rt_load_stall", load_stall, 1);
    chk("t3_rt_memfwd", mem_fwd_m, 0);

    // T4: dmem timeout
    @(negedge clk); idle(); dmem_req = 1; #1;
    chk("t4_enter_en", stage_en, 5'b10000);
    chk("t4_enter_rst", stage_rst, 5'b10000);
    @(negedge clk); #1;
    chk("t4_dwait_en", stage_en, 5'b10000);
    chk("t4_dwait_cnt", dut.wait_cnt, 0);
    got = 0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk); #1;
      if (mem_timeout) begin got = i; break; end
    end
    chk("t4_tmo_latency", got - 1, 15);
    chk("t4_tmo_rst", stage_rst, 5'b00111);
    chk("t4_tmo_en", stage_en, 5'h1F);
    @(negedge clk); idle(); #1;
    chk("t4_after_tmo", mem_timeout, 0);
    chk("t4_after_en", stage_en, 5'h1F);

    // Ack on the last wait cycle beats timeout
    @(negedge clk); dmem_req = 1; #1;
    for (int i = 0; i < 14; i++) begin @(negedge clk); #1; end
    @(negedge clk); dmem_ack = 1; #1;
    chk("ack_last_cnt", dut.wait_cnt, 14);
    chk("ack_last_en", stage_en, 5'b10000);
    @(negedge clk); idle(); #1;
    chk("ack_wins_tmo", mem_timeout, 0);
    chk("ack_wins_en", stage_en, 5'h1F);

    // T5: three-slot flush, then IWAIT freezes the count
    @(negedge clk); jump_en = 1; #1;
    chk("t5_s0", stage_rst, 5'b00010);
    @(negedge clk); jump_en = 0; #1;
    chk("t5_s1", stage_rst, 5'b00010);
    @(negedge clk); #1;
    chk("t5_s2", stage_rst, 5'b00010);
    @(negedge clk); #1;
    chk("t5_done", stage_rst, 5'b00000);
    @(negedge clk); jump_en = 1; #1;
    @(negedge clk); jump_en = 0; #1;
    chk("t5b_s1", stage_rst, 5'b00010);
    @(negedge clk); imem_req = 1; #1;
    chk("t5b_iw_rst", stage_rst, 5'b00100);
    chk("t5b_iw_en", stage_en, 5'b11100);
    chk("t5b_iw_cnt", dut.flush_cnt, 1);
    @(negedge clk); imem_ack = 1; #1;
    chk("t5b_iw2_rst", stage_rst, 5'b00100);
    chk("t5b_iw2_cnt", dut.flush_cnt, 1);
    @(negedge clk); idle(); #1;
    chk("t5b_s2", stage_rst, 5'b00010);
    @(negedge clk); #1;
    chk("t5b_done", stage_rst, 5'b00000);

    // T6: reset during DWAIT
    @(negedge clk); dmem_req = 1;
    repeat (3) @(negedge clk);
    rst = 1; #1;
    chk("t6_rst_en", stage_en, 5'h1F);
    chk("t6_rst_rst", stage_rst, 5'h1F);
    @(negedge clk); rst = 0; idle(); #1;
    chk("t6_cnt", dut.wait_cnt, 0);
    chk("t6_en", stage_en, 5'h1F);
    chk("t6_rst", stage_rst, 5'h00);
    chk("t6_tmo", mem_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
